// File: rtl/dff_pipe_if.sv
// Bus bundle for dff_pipe: advance/flush controls, stage-0 input, last-stage output and occupancy.
interface dff_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             clr;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [OCC_W-1:0] occ;

  modport master (
    output en, clr, d, d_valid,
    input  q, q_valid, occ
  );

  modport slave (
    input  en, clr, d, d_valid,
    output q, q_valid, occ
  );
endinterface

// File: rtl/dff_pipe.sv
// DEPTH-stage WIDTH-bit delay line with per-stage valid, advance enable, flush and occupancy count.
// Define DFF_PIPE_RST_DATA_EN to also load data stages with RST_VAL on reset.
module dff_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic      clk,
  input  logic      reset,
  dff_pipe_if.slave pipe
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [OCC_W-1:0]            occ_q, occ_d;

  // Next state: clr beats en; data is never touched by clr.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    occ_d  = occ_q;
    if (pipe.clr) begin
      vld_d = '0;
      occ_d = '0;
    end else if (pipe.en) begin
      data_d[0] = pipe.d;
      vld_d[0]  = pipe.d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      occ_d = occ_q + OCC_W'(pipe.d_valid) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

`ifdef DFF_PIPE_RST_DATA_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= {DEPTH{RST_VAL}};
    end else begin
      data_q <= data_d;
    end
  end
`else
  // Resetless data flops; RST_VAL only matters in the reset-data build.
  logic [WIDTH-1:0] unused_rst_val;
  assign unused_rst_val = RST_VAL;

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end
`endif

  assign pipe.q       = data_q[DEPTH-1];
  assign pipe.q_valid = vld_q[DEPTH-1];
  assign pipe.occ     = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus randomized traffic against a queue model.
module tb_dff_pipe;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam logic [W-1:0] RV = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst1 = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1)) b1 ();

  dff_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk(clk), .reset(rst), .pipe(bus.slave)
  );

  dff_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .pipe(b1.slave)
  );

  // Model: the last DEPTH words accepted on enabled edges, oldest first.
  typedef struct {
    logic [W-1:0] data;
    bit           vld;
  } ent_t;
  ent_t hist[$];

  function automatic void model_edge(bit r, bit c, bit e, logic [W-1:0] dv, bit v);
    ent_t x;
    if (r) begin
      hist.delete();
`ifdef DFF_PIPE_RST_DATA_EN
      for (int i = 0; i < int'(D); i++) begin
        x.data = RV; x.vld = 1'b0; hist.push_back(x);
      end
`endif
    end else if (c) begin
      foreach (hist[i]) hist[i].vld = 1'b0;
    end else if (e) begin
      x.data = dv; x.vld = v; hist.push_back(x);
      if (hist.size() > int'(D)) void'(hist.pop_front());
    end
  endfunction

  function automatic bit q_known();
    return hist.size() == int'(D);
  endfunction

  function automatic bit exp_qv();
    return q_known() ? hist[0].vld : 1'b0;
  endfunction

  function automatic int exp_occ();
    int n = 0;
    foreach (hist[i]) n += int'(hist[i].vld);
    return n;
  endfunction

  task automatic drive(input bit r, input bit c, input bit e, input logic [W-1:0] dv, input bit v);
    rst = r; bus.clr = c; bus.en = e; bus.d = dv; bus.d_valid = v;
    @(posedge clk);
    model_edge(r, c, e, dv, v);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 8'h00, 0);
    drive(1, 0, 0, 8'h00, 0);
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_qv got %0b exp 0", bus.q_valid); end
    n_checks++; if (bus.occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", bus.occ); end
`ifdef DFF_PIPE_RST_DATA_EN
    n_checks++; if (bus.q !== RV) begin n_fail++; $display("FAIL reset_q got %h exp %h", bus.q, RV); end
`endif
    drive(0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] w;
    int eo;
    drive(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      w  = (i < 4) ? W'(8'h11 * (i + 1)) : 8'h00;
      eo = (i < 4) ? i + 1 : 7 - i;
      drive(0, 0, 1, w, i < 4);
      n_checks++; if (int'(bus.occ) !== eo) begin n_fail++; $display("FAIL fill_occ[%0d] got %0d exp %0d", i, bus.occ, eo); end
      if (i >= 3 && i <= 6) begin
        n_checks++; if (bus.q_valid !== 1'b1 || bus.q !== W'(8'h11 * (i - 2))) begin
          n_fail++; $display("FAIL fill_q[%0d] got %h/%0b exp %h/1", i, bus.q, bus.q_valid, W'(8'h11 * (i - 2)));
        end
      end else begin
        n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL fill_qv[%0d] got %0b exp 0", i, bus.q_valid); end
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] qh;
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 8'hA1, 1);
    drive(0, 0, 1, 8'hA2, 1);
    qh = bus.q;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, W'($urandom), 1);
      n_checks++; if (bus.occ !== 3'd2 || bus.q_valid !== 1'b0 || bus.q !== qh) begin
        n_fail++; $display("FAIL stall[%0d] got occ=%0d qv=%0b q=%h exp occ=2 qv=0 q=%h", i, bus.occ, bus.q_valid, bus.q, qh);
      end
    end
    drive(0, 0, 1, 8'h00, 0);
    n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early got qv=%0b exp 0", bus.q_valid); end
    drive(0, 0, 1, 8'h00, 0);
    n_checks++; if (bus.q_valid !== 1'b1 || bus.q !== 8'hA1 || bus.occ !== 3'd2) begin
      n_fail++; $display("FAIL stall_resume got q=%h qv=%0b occ=%0d exp q=a1 qv=1 occ=2", bus.q, bus.q_valid, bus.occ);
    end
  endtask

  task automatic test_bubbles();
    logic [W-1:0] dv;
    bit v;
    drive(1, 0, 0, 8'h00, 0);
    for (int k = 1; k <= 7; k++) begin
      dv = (k <= 4) ? W'(k) : 8'h00;
      v  = (k <= 4) && (k % 2 == 1);
      drive(0, 0, 1, dv, v);
      n_checks++; if (bus.occ > 3'd2 || int'(bus.occ) !== exp_occ()) begin
        n_fail++; $display("FAIL bubble_occ[%0d] got %0d exp %0d (max 2)", k, bus.occ, exp_occ());
      end
      if (k >= 4) begin
        n_checks++; if (bus.q !== W'(k - 3) || bus.q_valid !== bit'((k - 3) % 2)) begin
          n_fail++; $display("FAIL bubble_q[%0d] got %h/%0b exp %h/%0b", k, bus.q, bus.q_valid, W'(k - 3), (k - 3) % 2);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] qh;
    drive(1, 0, 0, 8'h00, 0);
    drive(0, 0, 1, 8'hB1, 1);
    drive(0, 0, 1, 8'hB2, 1);
    drive(0, 0, 1, 8'hB3, 1);
    n_checks++; if (bus.occ !== 3'd3) begin n_fail++; $display("FAIL flush_pre_occ got %0d exp 3", bus.occ); end
    qh = bus.q;
    drive(0, 1, 1, 8'hFF, 1);
    n_checks++; if (bus.occ !== 3'd0 || bus.q_valid !== 1'b0 || bus.q !== qh) begin
      n_fail++; $display("FAIL flush got occ=%0d qv=%0b q=%h exp occ=0 qv=0 q=%h", bus.occ, bus.q_valid, bus.q, qh);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h00, 0);
    n_checks++; if (bus.q !== 8'hB3 || bus.q_valid !== 1'b0 || bus.occ !== 3'd0) begin
      n_fail++; $display("FAIL flush_after got q=%h qv=%0b occ=%0d exp q=b3 qv=0 occ=0", bus.q, bus.q_valid, bus.occ);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, W'(8'hC1 + i), 1);
    n_checks++; if (bus.occ !== 3'd4) begin n_fail++; $display("FAIL rmid_pre_occ got %0d exp 4", bus.occ); end
    drive(1, 0, 1, 8'hEE, 1);
    n_checks++; if (bus.occ !== 3'd0 || bus.q_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid got occ=%0d qv=%0b exp 0/0", bus.occ, bus.q_valid);
    end
`ifdef DFF_PIPE_RST_DATA_EN
    n_checks++; if (bus.q !== RV) begin n_fail++; $display("FAIL rmid_q got %h exp %h", bus.q, RV); end
`endif
    drive(0, 0, 1, 8'hD1, 1);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.q_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_early[%0d] got qv=%0b exp 0", i, bus.q_valid); end
      drive(0, 0, 1, 8'h00, 0);
    end
    n_checks++; if (bus.q !== 8'hD1 || bus.q_valid !== 1'b1 || bus.occ !== 3'd1) begin
      n_fail++; $display("FAIL rmid_emerge got q=%h qv=%0b occ=%0d exp d1/1/1", bus.q, bus.q_valid, bus.occ);
    end
  endtask

  task automatic test_random();
    bit r, c, e, v;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 29) == 0);
      e = ($urandom_range(0, 3) != 0);
      v = $urandom_range(0, 1) == 1;
      drive(r, c, e, W'($urandom), v);
      n_checks++; if (bus.q_valid !== exp_qv() || int'(bus.occ) !== exp_occ()) begin
        n_fail++; $display("FAIL rand_ctl[%0d] got qv=%0b occ=%0d exp qv=%0b occ=%0d", i, bus.q_valid, bus.occ, exp_qv(), exp_occ());
      end
      if (q_known()) begin
        n_checks++; if (bus.q !== hist[0].data) begin
          n_fail++; $display("FAIL rand_q[%0d] got %h exp %h", i, bus.q, hist[0].data);
        end
      end
    end
  endtask

  task automatic test_depth1();
    bit dv, v;
    rst1 = 1'b1; b1.en = 1'b1; b1.clr = 1'b0; b1.d = 1'b0; b1.d_valid = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    n_checks++; if (b1.q_valid !== 1'b0 || b1.occ !== 1'b0) begin
      n_fail++; $display("FAIL d1_reset got qv=%0b occ=%0d exp 0/0", b1.q_valid, b1.occ);
    end
    for (int i = 0; i < 24; i++) begin
      dv = bit'(i % 2);
      v  = $urandom_range(0, 1) == 1;
      b1.d = dv; b1.d_valid = v;
      @(posedge clk); #1;
      n_checks++; if (b1.q !== dv || b1.q_valid !== v || b1.occ !== v) begin
        n_fail++; $display("FAIL d1[%0d] got q=%0b qv=%0b occ=%0d exp %0b/%0b/%0b", i, b1.q, b1.q_valid, b1.occ, dv, v, v);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.clr = 1'b0; bus.d = '0; bus.d_valid = 1'b0;
    b1.en = 1'b0; b1.clr = 1'b0; b1.d = '0; b1.d_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_stall();
    test_bubbles();
    test_flush();
    test_reset_mid();
    test_random();
    test_depth1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
